// File: rtl/div_unit.sv
// RV32M divide/remainder unit: radix-2 restoring divider with a registered
// write-back port using a valid/ready handshake.
module div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start_in,
    input  logic [1:0]            div_op_in,
    input  logic [4:0]            div_rd_in,
    input  logic [DATA_WIDTH-1:0] div_rs1_data_in,
    input  logic [DATA_WIDTH-1:0] div_rs2_data_in,
    input  logic                  div_flush_in,
    output logic                  div_busy_out,
    output logic                  wb_wen_out,
    output logic [4:0]            wb_addr_out,
    output logic [DATA_WIDTH-1:0] wb_data_out,
    input  logic                  wb_ready_in
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            op_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] dvd_q;   // dividend shifts out, quotient shifts in
    logic [DATA_WIDTH-1:0] dsr_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic                  quo_neg_q;
    logic                  rem_neg_q;
    logic                  busy_q;
    logic                  wen_q;
    logic [4:0]            addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  a_neg, b_neg, div_zero, overflow, special;
    logic [DATA_WIDTH-1:0] a_abs, b_abs, special_res;
    logic [DATA_WIDTH:0]   shifted, trial;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_next, quo_next, fin_quo, fin_rem, fin_res;

    always_comb begin
        a_neg    = ~div_op_in[0] & div_rs1_data_in[DATA_WIDTH-1];
        b_neg    = ~div_op_in[0] & div_rs2_data_in[DATA_WIDTH-1];
        a_abs    = a_neg ? -div_rs1_data_in : div_rs1_data_in;
        b_abs    = b_neg ? -div_rs2_data_in : div_rs2_data_in;
        div_zero = (div_rs2_data_in == '0);
        overflow = ~div_op_in[0] && (div_rs1_data_in == MIN_INT) && (div_rs2_data_in == '1);
        special  = div_zero | overflow;
        if (div_zero) begin
            special_res = div_op_in[1] ? div_rs1_data_in : '1;
        end else begin
            special_res = div_op_in[1] ? '0 : MIN_INT;
        end
    end

    always_comb begin
        shifted  = {rem_q, dvd_q[DATA_WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        q_bit    = ~trial[DATA_WIDTH];
        rem_next = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        quo_next = {dvd_q[DATA_WIDTH-2:0], q_bit};
        fin_quo  = quo_neg_q ? -quo_next : quo_next;
        fin_rem  = rem_neg_q ? -rem_next : rem_next;
        fin_res  = op_q[1] ? fin_rem : fin_quo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start_in && !div_flush_in) begin
                        op_q      <= div_op_in;
                        rd_q      <= div_rd_in;
                        dvd_q     <= a_abs;
                        dsr_q     <= b_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        if (special) begin
                            data_q <= special_res;
                            addr_q <= div_rd_in;
                            // rd == 0 discards the result without occupying the port
                            if (div_rd_in != 5'd0) begin
                                state_q <= WB;
                                wen_q   <= 1'b1;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (div_flush_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_next;
                        dvd_q <= quo_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            data_q <= fin_res;
                            addr_q <= rd_q;
                            if (rd_q != 5'd0) begin
                                state_q <= WB;
                                wen_q   <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                WB: begin
                    if (div_flush_in || wb_ready_in) begin
                        state_q <= IDLE;
                        wen_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wen_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_busy_out = busy_q;
    assign wb_wen_out   = wen_q;
    assign wb_addr_out  = addr_q;
    assign wb_data_out  = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_start_in;
    logic [1:0]  div_op_in;
    logic [4:0]  div_rd_in;
    logic [31:0] div_rs1_data_in;
    logic [31:0] div_rs2_data_in;
    logic        div_flush_in;
    logic        div_busy_out;
    logic        wb_wen_out;
    logic [4:0]  wb_addr_out;
    logic [31:0] wb_data_out;
    logic        wb_ready_in;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .div_start_in    (div_start_in),
        .div_op_in       (div_op_in),
        .div_rd_in       (div_rd_in),
        .div_rs1_data_in (div_rs1_data_in),
        .div_rs2_data_in (div_rs2_data_in),
        .div_flush_in    (div_flush_in),
        .div_busy_out    (div_busy_out),
        .wb_wen_out      (wb_wen_out),
        .wb_addr_out     (wb_addr_out),
        .wb_data_out     (wb_data_out),
        .wb_ready_in     (wb_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics from plain integer arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0: ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'd1: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: ref_result = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: ref_result = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        is_special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b);
        div_start_in    = 1'b1;
        div_op_in       = op;
        div_rd_in       = rd;
        div_rs1_data_in = a;
        div_rs2_data_in = b;
    endtask

    // Issue one op with ready held high and check latency, address, data, release.
    task automatic run_op(input string name, input logic [1:0] op, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat, k;
        exp = ref_result(op, a, b);
        lat = is_special(op, a, b) ? 0 : 32;
        wb_ready_in = 1'b1;
        issue(op, rd, a, b);
        tick();  // E0
        div_start_in = 1'b0;
        n_checks++;
        if (div_busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after accept: got %b want 1", name, div_busy_out);
        end
        k = 0;
        while (wb_wen_out !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (k !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        n_checks++;
        if (wb_addr_out !== rd || wb_data_out !== exp) begin
            n_fail++;
            $display("FAIL %s result: got rd=%0d data=%h want rd=%0d data=%h",
                     name, wb_addr_out, wb_data_out, rd, exp);
        end
        tick();
        n_checks++;
        if (wb_wen_out !== 1'b0 || div_busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: got wen=%b busy=%b want 0 0", name, wb_wen_out,
                     div_busy_out);
        end
    endtask

    task automatic expect_no_wen(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (wb_wen_out === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL %s spurious write-back: got wen seen=1 want 0", name);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        div_start_in = 1'b0;
        div_op_in    = 2'd0;
        div_rd_in    = 5'd0;
        div_rs1_data_in = 32'h0;
        div_rs2_data_in = 32'h0;
        div_flush_in = 1'b0;
        wb_ready_in  = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({div_busy_out, wb_wen_out, wb_addr_out, wb_data_out} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset outputs: got busy=%b wen=%b addr=%0d data=%h want all 0",
                     div_busy_out, wb_wen_out, wb_addr_out, wb_data_out);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_op("div_20_3", 2'd0, 5'd5, 32'd20, 32'd3);
        run_op("rem_m7_2", 2'd2, 5'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("div_m7_2", 2'd0, 5'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("remu_f9_2", 2'd3, 5'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", 2'd0, 5'd8, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_special();
        run_op("divu_by0", 2'd1, 5'd7, 32'd7, 32'd0);
        run_op("remu_by0", 2'd3, 5'd7, 32'd7, 32'd0);
        run_op("rem_by0", 2'd2, 5'd7, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", 2'd0, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 2'd2, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_no_ovf", 2'd1, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_stall();
        logic [4:0]  a0;
        logic [31:0] d0;
        bit unstable;
        int k;
        wb_ready_in = 1'b0;
        issue(2'd0, 5'd3, 32'd100, 32'd7);
        tick();
        div_start_in = 1'b0;
        k = 0;
        while (wb_wen_out !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        a0 = wb_addr_out;
        d0 = wb_data_out;
        unstable = 1'b0;
        issue(2'd1, 5'd9, 32'd50, 32'd5);  // must be ignored while busy
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wb_wen_out !== 1'b1 || wb_addr_out !== a0 || wb_data_out !== d0) unstable = 1;
        end
        div_start_in = 1'b0;
        n_checks++;
        if (unstable !== 1'b0 || a0 !== 5'd3 || d0 !== 32'd14) begin
            n_fail++;
            $display("FAIL stall hold: got unstable=%b rd=%0d data=%h want 0 3 0000000e",
                     unstable, a0, d0);
        end
        wb_ready_in = 1'b1;
        tick();
        n_checks++;
        if (wb_wen_out !== 1'b0 || div_busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stall release: got wen=%b busy=%b want 0 0", wb_wen_out,
                     div_busy_out);
        end
        expect_no_wen("stall_second_start", 40);
    endtask

    task automatic test_flush();
        // Flush while the counter reads 10
        wb_ready_in = 1'b1;
        issue(2'd0, 5'd4, 32'd1000, 32'd3);
        tick();
        div_start_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        div_flush_in = 1'b1;
        tick();
        div_flush_in = 1'b0;
        n_checks++;
        if (div_busy_out !== 1'b0 || wb_wen_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc: got busy=%b wen=%b want 0 0", div_busy_out, wb_wen_out);
        end
        expect_no_wen("flush_calc", 40);
        // Flush in WB together with ready
        issue(2'd1, 5'd4, 32'd7, 32'd0);
        tick();
        div_start_in = 1'b0;
        div_flush_in = 1'b1;
        tick();
        div_flush_in = 1'b0;
        n_checks++;
        if (div_busy_out !== 1'b0 || wb_wen_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_wb: got busy=%b wen=%b want 0 0", div_busy_out, wb_wen_out);
        end
        // Flush and start together in idle: nothing accepted
        issue(2'd0, 5'd4, 32'd9, 32'd0);
        div_flush_in = 1'b1;
        tick();
        div_start_in = 1'b0;
        div_flush_in = 1'b0;
        n_checks++;
        if (div_busy_out !== 1'b0 || wb_wen_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start: got busy=%b wen=%b want 0 0", div_busy_out,
                     wb_wen_out);
        end
        expect_no_wen("flush_start", 3);
    endtask

    task automatic test_rd_zero();
        bit seen, busy31, busy32;
        seen = 1'b0;
        issue(2'd0, 5'd0, 32'd20, 32'd3);
        tick();  // E0
        div_start_in = 1'b0;
        busy31 = 1'b0;
        busy32 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (wb_wen_out === 1'b1) seen = 1'b1;
            if (k == 31) busy31 = div_busy_out;
            if (k == 32) busy32 = div_busy_out;
        end
        n_checks++;
        if (seen !== 1'b0 || busy31 !== 1'b1 || busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_zero: got wen_seen=%b busy@31=%b busy@32=%b want 0 1 0",
                     seen, busy31, busy32);
        end
        issue(2'd1, 5'd0, 32'd5, 32'd0);
        tick();
        div_start_in = 1'b0;
        n_checks++;
        if (div_busy_out !== 1'b0 || wb_wen_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_zero_special: got busy=%b wen=%b want 0 0", div_busy_out,
                     wb_wen_out);
        end
    endtask

    task automatic test_async_reset();
        issue(2'd1, 5'd11, 32'd12345, 32'd17);
        tick();
        div_start_in = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({div_busy_out, wb_wen_out, wb_addr_out, wb_data_out} !== 39'h0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b wen=%b addr=%0d data=%h want all 0",
                     div_busy_out, wb_wen_out, wb_addr_out, wb_data_out);
        end
        tick();
        rst = 1'b1;
        expect_no_wen("async_reset", 40);
        run_op("divu_9_4", 2'd1, 5'd12, 32'd9, 32'd4);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  op;
        logic [4:0]  rd;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            rd = 5'($urandom_range(1, 31));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 99));
                default: ;
            endcase
            run_op("random", op, rd, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_stall();
        test_flush();
        test_rd_zero();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
